scoreboard_ctrl: RTL and testbench

SCOREBOARD_CTRL -- requirements
Module: scoreboard_ctrl

---
 rtl/scoreboard_ctrl.sv | 137 +++++++++++++
 tb/tb_scoreboard_ctrl.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scoreboard_ctrl.sv
// Run controller for a free-running scoreboard: clears it, unfreezes it for a
// programmed number of cycles, then captures its counters for the host.
module scoreboard_ctrl #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic [WIDTH-1:0] i_length,
  input  logic             i_ack,
  input  logic [WIDTH-1:0] i_sb_event_ctr,
  input  logic [WIDTH-1:0] i_sb_data_ctr,
  output logic             o_sb_clear,
  output logic             o_sb_freeze,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_res_events,
  output logic [WIDTH-1:0] o_res_data,
  output logic             o_pass,
  output logic             o_aborted
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_RUN    = 3'd2,
    S_SETTLE = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;
  logic             aborted_d;
  logic             pass_d;
  logic [WIDTH-1:0] res_events_d;
  logic [WIDTH-1:0] res_data_d;

  // Next-state and next-value logic; the counter holds the remaining RUN cycles.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    aborted_d    = o_aborted;
    pass_d       = o_pass;
    res_events_d = o_res_events;
    res_data_d   = o_res_data;

    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          state_d   = S_CLEAR;
          cnt_d     = i_length;
          aborted_d = 1'b0;
        end
      end

      S_CLEAR: begin
        if (i_abort) begin
          state_d   = S_SETTLE;
          cnt_d     = '0;
          aborted_d = 1'b1;
        end else if (cnt_q == '0) begin
          state_d = S_SETTLE;
        end else begin
          state_d = S_RUN;
        end
      end

      // Terminal count is 1, so an all-ones length never wraps.
      S_RUN: begin
        if (i_abort) begin
          state_d   = S_SETTLE;
          cnt_d     = '0;
          aborted_d = 1'b1;
        end else if (cnt_q <= WIDTH'(1)) begin
          state_d = S_SETTLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - WIDTH'(1);
        end
      end

      S_SETTLE: begin
        state_d      = S_DONE;
        res_events_d = i_sb_event_ctr;
        res_data_d   = i_sb_data_ctr;
        pass_d       = (i_sb_event_ctr == '0) && !o_aborted;
      end

      S_DONE: begin
        if (i_ack) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Outputs are decoded from the next state so every strobe comes from a flop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q        <= '0;
      o_sb_clear   <= 1'b1;
      o_sb_freeze  <= 1'b1;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
      o_pass       <= 1'b0;
      o_aborted    <= 1'b0;
      o_res_events <= '0;
      o_res_data   <= '0;
    end else begin
      cnt_q        <= cnt_d;
      o_sb_clear   <= (state_d == S_CLEAR);
      o_sb_freeze  <= (state_d != S_RUN);
      o_busy       <= (state_d == S_CLEAR) || (state_d == S_RUN) || (state_d == S_SETTLE);
      o_done       <= (state_d == S_DONE);
      o_pass       <= pass_d;
      o_aborted    <= aborted_d;
      o_res_events <= res_events_d;
      o_res_data   <= res_data_d;
    end
  end

endmodule

// File: tb/tb_scoreboard_ctrl.sv
// Bench for scoreboard_ctrl: a behavioural scoreboard is attached and expected
// results are queued at stimulus time, then compared when o_done rises.
module tb_scoreboard_ctrl;

  localparam int unsigned WIDTH = 32;

  logic             clk;
  logic             reset_n;
  logic             i_start;
  logic             i_abort;
  logic [WIDTH-1:0] i_length;
  logic             i_ack;
  logic [WIDTH-1:0] sb_ev;
  logic [WIDTH-1:0] sb_data;
  logic             sb_event;
  logic             o_sb_clear;
  logic             o_sb_freeze;
  logic             o_busy;
  logic             o_done;
  logic [WIDTH-1:0] o_res_events;
  logic [WIDTH-1:0] o_res_data;
  logic             o_pass;
  logic             o_aborted;

  typedef struct {
    logic [WIDTH-1:0] ev;
    logic [WIDTH-1:0] data;
    logic             pass;
    logic             ab;
  } exp_t;

  exp_t exp_q[$];
  int   total;
  int   bad;

  scoreboard_ctrl #(.WIDTH(WIDTH)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .i_start       (i_start),
    .i_abort       (i_abort),
    .i_length      (i_length),
    .i_ack         (i_ack),
    .i_sb_event_ctr(sb_ev),
    .i_sb_data_ctr (sb_data),
    .o_sb_clear    (o_sb_clear),
    .o_sb_freeze   (o_sb_freeze),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_res_events  (o_res_events),
    .o_res_data    (o_res_data),
    .o_pass        (o_pass),
    .o_aborted     (o_aborted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard model: counts every unfrozen cycle, and events when sb_event is high.
  always @(posedge clk) begin
    if (o_sb_clear) begin
      sb_ev   <= '0;
      sb_data <= '0;
    end else if (!o_sb_freeze) begin
      sb_data <= sb_data + 32'd1;
      if (sb_event) sb_ev <= sb_ev + 32'd1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic kick(input logic [WIDTH-1:0] len);
    i_length = len;
    i_start  = 1'b1;
    tick();
    i_start  = 1'b0;
  endtask

  // Steps the run from CLEAR to DONE, driving events/abort by RUN-cycle index.
  task automatic observe_run(input logic [127:0] pat, input int abort_at,
                             output int clear_cyc, output int low_cyc,
                             output int done_iter, output bit timeout);
    int  run_idx;
    bit  found;
    run_idx   = 0;
    found     = 1'b0;
    clear_cyc = 0;
    low_cyc   = 0;
    done_iter = -1;
    for (int i = 0; i < 300; i++) begin
      if (!found) begin
        if (o_done) begin
          found     = 1'b1;
          done_iter = i;
        end else begin
          if (o_sb_clear) clear_cyc++;
          if (!o_sb_freeze) begin
            run_idx++;
            low_cyc++;
            sb_event = (run_idx <= 128) ? pat[run_idx-1] : 1'b0;
            i_abort  = (run_idx == abort_at);
          end else begin
            sb_event = 1'b0;
            i_abort  = 1'b0;
          end
          tick();
        end
      end
    end
    sb_event = 1'b0;
    i_abort  = 1'b0;
    timeout  = !found;
  endtask

  task automatic test_reset();
    tick(); tick(); tick();
    total++; if (o_sb_clear !== 1'b1) begin bad++; $display("FAIL rst_clear: got %0b want 1", o_sb_clear); end
    total++; if (o_sb_freeze !== 1'b1) begin bad++; $display("FAIL rst_freeze: got %0b want 1", o_sb_freeze); end
    total++; if ({o_busy, o_done, o_pass, o_aborted} !== 4'b0000) begin bad++; $display("FAIL rst_flags: got %b want 0000", {o_busy, o_done, o_pass, o_aborted}); end
    total++; if ({o_res_events, o_res_data} !== 64'd0) begin bad++; $display("FAIL rst_results: got %0h/%0h want 0/0", o_res_events, o_res_data); end
    reset_n = 1'b1;
    tick();
    total++; if (o_sb_clear !== 1'b0) begin bad++; $display("FAIL rst_release_clear: got %0b want 0", o_sb_clear); end
    total++; if (o_sb_freeze !== 1'b1 || o_busy !== 1'b0) begin bad++; $display("FAIL rst_release_idle: freeze=%0b busy=%0b want 1/0", o_sb_freeze, o_busy); end
  endtask

  task automatic test_basic();
    exp_t e;
    int   cc, lc, di;
    bit   to;
    exp_q.push_back('{ev: 32'd0, data: 32'd5, pass: 1'b1, ab: 1'b0});
    kick(32'd5);
    total++; if (o_sb_clear !== 1'b1 || o_busy !== 1'b1) begin bad++; $display("FAIL basic_clear_state: clear=%0b busy=%0b want 1/1", o_sb_clear, o_busy); end
    observe_run('0, 0, cc, lc, di, to);
    e = exp_q.pop_front();
    total++; if (to) begin bad++; $display("FAIL basic_timeout: o_done never rose"); end
    total++; if (cc !== 1) begin bad++; $display("FAIL basic_clear_cycles: got %0d want 1", cc); end
    total++; if (lc !== 5) begin bad++; $display("FAIL basic_unfrozen_cycles: got %0d want 5", lc); end
    total++; if (di !== 7) begin bad++; $display("FAIL basic_latency: got %0d want 7", di); end
    total++; if (o_res_data !== e.data || o_res_events !== e.ev) begin bad++; $display("FAIL basic_results: got %0d/%0d want %0d/%0d", o_res_events, o_res_data, e.ev, e.data); end
    total++; if (o_pass !== e.pass || o_aborted !== e.ab || o_busy !== 1'b0) begin bad++; $display("FAIL basic_flags: pass=%0b ab=%0b busy=%0b want %0b/%0b/0", o_pass, o_aborted, o_busy, e.pass, e.ab); end
    i_ack = 1'b1; tick(); i_ack = 1'b0;
    total++; if (o_done !== 1'b0 || o_busy !== 1'b0) begin bad++; $display("FAIL basic_ack_idle: done=%0b busy=%0b want 0/0", o_done, o_busy); end
    i_abort = 1'b1; tick(); i_abort = 1'b0; tick();
    total++; if (o_busy !== 1'b0 || o_aborted !== 1'b0) begin bad++; $display("FAIL idle_abort_ignored: busy=%0b ab=%0b want 0/0", o_busy, o_aborted); end
    total++; if (o_res_data !== 32'd5 || o_pass !== 1'b1) begin bad++; $display("FAIL idle_results_kept: data=%0d pass=%0b want 5/1", o_res_data, o_pass); end
  endtask

  task automatic test_events();
    exp_t e;
    int   cc, lc, di;
    bit   to;
    exp_q.push_back('{ev: 32'd3, data: 32'd8, pass: 1'b0, ab: 1'b0});
    kick(32'd8);
    i_length = 32'd1;
    observe_run(128'b0010_1010, 0, cc, lc, di, to);
    e = exp_q.pop_front();
    total++; if (to) begin bad++; $display("FAIL events_timeout: o_done never rose"); end
    total++; if (lc !== 8) begin bad++; $display("FAIL events_unfrozen_cycles: got %0d want 8", lc); end
    total++; if (o_res_events !== e.ev || o_res_data !== e.data) begin bad++; $display("FAIL events_results: got %0d/%0d want %0d/%0d", o_res_events, o_res_data, e.ev, e.data); end
    total++; if (o_pass !== e.pass || o_aborted !== e.ab) begin bad++; $display("FAIL events_flags: pass=%0b ab=%0b want %0b/%0b", o_pass, o_aborted, e.pass, e.ab); end
    i_ack = 1'b1; tick(); i_ack = 1'b0;
  endtask

  task automatic test_zero_length();
    exp_t e;
    int   cc, lc, di;
    bit   to;
    exp_q.push_back('{ev: 32'd0, data: 32'd0, pass: 1'b1, ab: 1'b0});
    kick(32'd0);
    observe_run('0, 0, cc, lc, di, to);
    e = exp_q.pop_front();
    total++; if (to) begin bad++; $display("FAIL zero_timeout: o_done never rose"); end
    total++; if (cc !== 1 || lc !== 0 || di !== 2) begin bad++; $display("FAIL zero_sequence: clear=%0d low=%0d done_at=%0d want 1/0/2", cc, lc, di); end
    total++; if (o_res_data !== e.data || o_pass !== e.pass) begin bad++; $display("FAIL zero_results: data=%0d pass=%0b want %0d/%0b", o_res_data, o_pass, e.data, e.pass); end
    i_ack = 1'b1; tick(); i_ack = 1'b0;
  endtask

  task automatic test_abort();
    exp_t e;
    int   cc, lc, di;
    bit   to;
    exp_q.push_back('{ev: 32'd0, data: 32'd10, pass: 1'b0, ab: 1'b1});
    kick(32'd100);
    observe_run('0, 10, cc, lc, di, to);
    e = exp_q.pop_front();
    total++; if (to) begin bad++; $display("FAIL abort_timeout: o_done never rose"); end
    total++; if (lc !== 10 || di !== 12) begin bad++; $display("FAIL abort_sequence: low=%0d done_at=%0d want 10/12", lc, di); end
    total++; if (o_res_data !== e.data || o_res_events !== e.ev) begin bad++; $display("FAIL abort_results: got %0d/%0d want %0d/%0d", o_res_events, o_res_data, e.ev, e.data); end
    total++; if (o_aborted !== e.ab || o_pass !== e.pass) begin bad++; $display("FAIL abort_flags: ab=%0b pass=%0b want %0b/%0b", o_aborted, o_pass, e.ab, e.pass); end
    i_ack = 1'b1; tick(); i_ack = 1'b0;
    total++; if (o_aborted !== 1'b1) begin bad++; $display("FAIL abort_kept_idle: got %0b want 1", o_aborted); end
  endtask

  task automatic test_max_length();
    exp_t e;
    int   cc, lc, di;
    bit   to;
    exp_q.push_back('{ev: 32'd0, data: 32'd30, pass: 1'b0, ab: 1'b1});
    kick('1);
    total++; if (o_aborted !== 1'b0) begin bad++; $display("FAIL start_clears_abort: got %0b want 0", o_aborted); end
    observe_run('0, 30, cc, lc, di, to);
    e = exp_q.pop_front();
    total++; if (to) begin bad++; $display("FAIL maxlen_timeout: o_done never rose"); end
    total++; if (lc !== 30 || o_res_data !== e.data) begin bad++; $display("FAIL maxlen_run: low=%0d data=%0d want 30/%0d", lc, o_res_data, e.data); end
    i_ack = 1'b1; tick(); i_ack = 1'b0;
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   cc, lc, di;
    bit   to;
    exp_q.push_back('{ev: 32'd1, data: 32'd3, pass: 1'b0, ab: 1'b0});
    i_length = 32'd3;
    i_start  = 1'b1;
    tick();
    observe_run(128'b1, 0, cc, lc, di, to);
    e = exp_q.pop_front();
    total++; if (to) begin bad++; $display("FAIL b2b_timeout: o_done never rose"); end
    for (int i = 0; i < 20; i++) begin
      total++;
      if (o_done !== 1'b1 || o_busy !== 1'b0 || o_res_events !== e.ev || o_res_data !== e.data || o_pass !== e.pass) begin
        bad++;
        $display("FAIL b2b_hold[%0d]: done=%0b busy=%0b ev=%0d data=%0d pass=%0b want 1/0/%0d/%0d/%0b",
                 i, o_done, o_busy, o_res_events, o_res_data, o_pass, e.ev, e.data, e.pass);
      end
      tick();
    end
    i_length = 32'd4;
    i_ack = 1'b1; tick(); i_ack = 1'b0;
    total++; if (o_done !== 1'b0 || o_busy !== 1'b0 || o_sb_clear !== 1'b0) begin bad++; $display("FAIL b2b_idle: done=%0b busy=%0b clear=%0b want 0/0/0", o_done, o_busy, o_sb_clear); end
    exp_q.push_back('{ev: 32'd0, data: 32'd4, pass: 1'b1, ab: 1'b0});
    tick();
    i_start = 1'b0;
    total++; if (o_sb_clear !== 1'b1 || o_busy !== 1'b1) begin bad++; $display("FAIL b2b_restart: clear=%0b busy=%0b want 1/1", o_sb_clear, o_busy); end
    observe_run('0, 0, cc, lc, di, to);
    e = exp_q.pop_front();
    total++; if (to || o_res_data !== e.data || o_pass !== e.pass) begin bad++; $display("FAIL b2b_second: timeout=%0b data=%0d pass=%0b want 0/%0d/%0b", to, o_res_data, o_pass, e.data, e.pass); end
    i_ack = 1'b1; tick(); i_ack = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    int done_seen;
    done_seen = 0;
    kick(32'd50);
    tick(); tick(); tick(); tick(); tick();
    total++; if (o_sb_freeze !== 1'b0) begin bad++; $display("FAIL midrst_in_run: freeze=%0b want 0", o_sb_freeze); end
    #2;
    reset_n = 1'b0;
    #1;
    total++; if (o_sb_clear !== 1'b1 || o_sb_freeze !== 1'b1) begin bad++; $display("FAIL midrst_async_strobes: clear=%0b freeze=%0b want 1/1", o_sb_clear, o_sb_freeze); end
    total++; if ({o_busy, o_done, o_pass, o_aborted} !== 4'b0000) begin bad++; $display("FAIL midrst_async_flags: got %b want 0000", {o_busy, o_done, o_pass, o_aborted}); end
    total++; if ({o_res_events, o_res_data} !== 64'd0) begin bad++; $display("FAIL midrst_results: got %0d/%0d want 0/0", o_res_events, o_res_data); end
    for (int i = 0; i < 4; i++) begin
      tick();
      if (o_done) done_seen++;
    end
    reset_n = 1'b1;
    tick();
    total++; if (o_sb_clear !== 1'b0 || o_busy !== 1'b0) begin bad++; $display("FAIL midrst_release: clear=%0b busy=%0b want 0/0", o_sb_clear, o_busy); end
    for (int i = 0; i < 60; i++) begin
      if (o_done || o_busy) done_seen++;
      tick();
    end
    total++; if (done_seen !== 0) begin bad++; $display("FAIL midrst_no_done: saw %0d done/busy cycles want 0", done_seen); end
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    reset_n  = 1'b0;
    i_start  = 1'b0;
    i_abort  = 1'b0;
    i_ack    = 1'b0;
    i_length = '0;
    sb_event = 1'b0;
    test_reset();
    test_basic();
    test_events();
    test_zero_length();
    test_abort();
    test_max_length();
    test_back_to_back();
    test_reset_mid_run();
    total++; if (exp_q.size() !== 0) begin bad++; $display("FAIL scoreboard_drain: %0d entries left want 0", exp_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
